// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants, arbiter state type and index helpers for the GPU framebuffer bus.
package gpu_pkg;
    localparam int          GPU_M_RASTER     = 0;
    localparam int          GPU_M_CPU        = 1;
    localparam int          GPU_M_BLIT       = 2;
    localparam logic [31:0] GPU_FB_BASE      = 32'h2000_0000;
    localparam logic [31:0] GPU_BUS_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    // Circular add that wraps modulo n (n need not be a power of two).
    function automatic int wrap_add(input int base, input int off, input int n);
        return base + off >= n ? base + off - n : base + off;
    endfunction
endpackage

// File: rtl/gpu_rr_pick.sv
// gpu_rr_pick: combinational round-robin picker, first requester after i_last in circular order.
module gpu_rr_pick
    import gpu_pkg::*;
#(
    parameter int NUM_M = 3,
    parameter int IW    = idx_w(NUM_M)
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [IW-1:0]    i_last,
    output logic             o_found,
    output logic [IW-1:0]    o_idx
);
    // Walk from farthest to nearest so the nearest requester after i_last wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NUM_M; i >= 1; i--) begin
            if (i_req[IW'(wrap_add(int'(i_last), i, NUM_M))]) begin
                o_found = 1'b1;
                o_idx   = IW'(wrap_add(int'(i_last), i, NUM_M));
            end
        end
    end
endmodule

// File: rtl/gpu_fb_arbiter.sv
// gpu_fb_arbiter: round-robin Wishbone arbiter holding a grant for a master's whole cyc tenure.
// Define GPU_FB_ARB_TIMEOUT_EN to add a watchdog that breaks transfers stalled TIMEOUT_CYCLES.
module gpu_fb_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_M          = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M-1:0]    m_cyc_i,
    input  logic [NUM_M-1:0]    m_stb_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [4*NUM_M-1:0]  m_sel_i,
    input  logic [32*NUM_M-1:0] m_adr_i,
    input  logic [32*NUM_M-1:0] m_dat_i,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [31:0]         m_dat_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [3:0]          s_sel_o,
    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    input  logic [31:0]         s_dat_i,
    input  logic                s_ack_i,
    output logic [NUM_M-1:0]    grant_o,
    output logic                timeout_o
);
    localparam int IW = idx_w(NUM_M);

    arb_state_t       r_state;
    logic [IW-1:0]    r_gnt;
    logic [IW-1:0]    r_last;
    logic             w_found;
    logic [IW-1:0]    w_idx;
    logic             w_own;
    logic             w_stb;
    logic             w_fire;
    logic [NUM_M-1:0] w_gnt_oh;

    gpu_rr_pick #(.NUM_M(NUM_M), .IW(IW)) u_pick (
        .i_req   (m_cyc_i),
        .i_last  (r_last),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_last  <= IW'(NUM_M - 1);
        end else if (r_state == ARB_IDLE) begin
            if (w_found) begin
                r_state <= ARB_OWN;
                r_gnt   <= w_idx;
            end
        end else if (!m_cyc_i[r_gnt]) begin
            r_state <= ARB_IDLE;
            r_last  <= r_gnt;
        end
    end

    assign w_own    = r_state == ARB_OWN;
    assign w_stb    = w_own & m_stb_i[r_gnt];
    assign w_gnt_oh = w_own ? NUM_M'(1) << r_gnt : '0;

`ifdef GPU_FB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_wd;
    assign w_fire = w_stb & ~s_ack_i & (r_wd == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst || !w_own || s_ack_i || w_fire)
            r_wd <= '0;
        else if (w_stb)
            r_wd <= r_wd + 1'b1;
    end
`else
    assign w_fire = 1'b0;
`endif

    // The watchdog answers the owner with an error word and hides the cycle from the slave.
    assign s_cyc_o   = w_own & m_cyc_i[r_gnt] & ~w_fire;
    assign s_stb_o   = w_stb & ~w_fire;
    assign s_we_o    = w_own & m_we_i[r_gnt];
    assign s_sel_o   = w_own ? m_sel_i[r_gnt*4 +: 4] : '0;
    assign s_adr_o   = w_own ? m_adr_i[r_gnt*32 +: 32] : '0;
    assign s_dat_o   = w_own ? m_dat_i[r_gnt*32 +: 32] : '0;
    assign m_ack_o   = (s_ack_i | w_fire) ? w_gnt_oh : '0;
    assign m_dat_o   = w_fire ? GPU_BUS_ERR_DATA : s_dat_i;
    assign grant_o   = w_gnt_oh;
    assign timeout_o = w_fire;
endmodule

// File: tb/tb_gpu_fb_arbiter.sv
// tb_gpu_fb_arbiter: directed self-checking bench for gpu_fb_arbiter.
module tb_gpu_fb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
    logic [11:0] m_sel_i = '0;
    logic [95:0] m_adr_i = '0, m_dat_i = '0;
    logic [2:0]  m_ack_o;
    logic [31:0] m_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 1'b0;
    logic [2:0]  grant_o;
    logic        timeout_o;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    gpu_fb_arbiter #(.NUM_M(3), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc_i[k] = cyc;
        m_stb_i[k] = stb;
        m_we_i[k]  = we;
        m_sel_i[4*k +: 4]   = 4'hF;
        m_adr_i[32*k +: 32] = adr;
        m_dat_i[32*k +: 32] = dat;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; s_ack_i = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b1, 32'h2000_0010, 32'h5555_AAAA);
        s_dat_i = 32'h0000_1234;
        tick; smp;
        if (s_cyc_o !== 1'b0) $display("FAIL rst_s_cyc got=%b exp=0", s_cyc_o); else n_pass++; n_total++;
        if (s_stb_o !== 1'b0) $display("FAIL rst_s_stb got=%b exp=0", s_stb_o); else n_pass++; n_total++;
        if (s_we_o !== 1'b0) $display("FAIL rst_s_we got=%b exp=0", s_we_o); else n_pass++; n_total++;
        if (s_sel_o !== 4'h0) $display("FAIL rst_s_sel got=%h exp=0", s_sel_o); else n_pass++; n_total++;
        if (s_adr_o !== 32'h0) $display("FAIL rst_s_adr got=%h exp=0", s_adr_o); else n_pass++; n_total++;
        if (s_dat_o !== 32'h0) $display("FAIL rst_s_dat got=%h exp=0", s_dat_o); else n_pass++; n_total++;
        if (m_ack_o !== 3'b000) $display("FAIL rst_m_ack got=%b exp=000", m_ack_o); else n_pass++; n_total++;
        if (grant_o !== 3'b000) $display("FAIL rst_grant got=%b exp=000", grant_o); else n_pass++; n_total++;
        if (timeout_o !== 1'b0) $display("FAIL rst_timeout got=%b exp=0", timeout_o); else n_pass++; n_total++;
        if (m_dat_o !== 32'h0000_1234) $display("FAIL rst_m_dat got=%h exp=00001234", m_dat_o); else n_pass++; n_total++;
        do_reset;
    endtask

    task automatic test_first_owner;
        do_reset;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h2000_0040, 32'h0);
        smp;
        if (grant_o !== 3'b000) $display("FAIL first_idle grant got=%b exp=000", grant_o); else n_pass++; n_total++;
        tick; smp;
        if (grant_o !== 3'b001) $display("FAIL first_grant got=%b exp=001", grant_o); else n_pass++; n_total++;
        if (s_adr_o !== 32'h2000_0040) $display("FAIL first_adr got=%h exp=20000040", s_adr_o); else n_pass++; n_total++;
        if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) $display("FAIL first_cyc_stb got=%b%b exp=11", s_cyc_o, s_stb_o); else n_pass++; n_total++;
        if (m_ack_o !== 3'b000) $display("FAIL first_noack got=%b exp=000", m_ack_o); else n_pass++; n_total++;
        tick; tick;
        s_ack_i = 1'b1; s_dat_i = 32'h0000_0080;
        smp;
        if (m_ack_o !== 3'b001) $display("FAIL first_ack got=%b exp=001", m_ack_o); else n_pass++; n_total++;
        if (m_dat_o !== 32'h0000_0080) $display("FAIL first_rdata got=%h exp=00000080", m_dat_o); else n_pass++; n_total++;
        tick;
        s_ack_i = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        smp;
        if (s_cyc_o !== 1'b0) $display("FAIL first_drop_cyc got=%b exp=0", s_cyc_o); else n_pass++; n_total++;
        if (grant_o !== 3'b001) $display("FAIL first_release_grant got=%b exp=001", grant_o); else n_pass++; n_total++;
        tick; smp;
        if (grant_o !== 3'b000) $display("FAIL first_idle_after got=%b exp=000", grant_o); else n_pass++; n_total++;
    endtask

    task automatic test_round_robin;
        int seq[4] = '{0, 1, 2, 0};
        logic [2:0] oh;
        do_reset;
        for (int k = 0; k < 3; k++) drive(k, 1'b1, 1'b1, 1'b0, 32'h2000_0100 + 32'(k * 4), 32'h0);
        for (int n = 0; n < 4; n++) begin
            oh = 3'b001 << seq[n];
            smp;
            if (grant_o !== 3'b000) $display("FAIL rr_idle%0d got=%b exp=000", n, grant_o); else n_pass++; n_total++;
            tick;
            s_ack_i = 1'b1;
            smp;
            if (grant_o !== oh) $display("FAIL rr_grant%0d got=%b exp=%b", n, grant_o, oh); else n_pass++; n_total++;
            if (m_ack_o !== oh) $display("FAIL rr_ack%0d got=%b exp=%b", n, m_ack_o, oh); else n_pass++; n_total++;
            if (s_adr_o !== 32'h2000_0100 + 32'(seq[n] * 4)) $display("FAIL rr_adr%0d got=%h", n, s_adr_o); else n_pass++; n_total++;
            tick;
            s_ack_i = 1'b0;
            m_cyc_i[seq[n]] = 1'b0;
            smp;
            if (s_cyc_o !== 1'b0) $display("FAIL rr_release%0d got=%b exp=0", n, s_cyc_o); else n_pass++; n_total++;
            tick;
            m_cyc_i[seq[n]] = 1'b1;
        end
        m_cyc_i = '0; m_stb_i = '0;
    endtask

    task automatic test_rmw;
        do_reset;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h2000_0044, 32'h0);
        drive(2, 1'b1, 1'b1, 1'b1, 32'h2000_0200, 32'hCAFE_0002);
        tick;
        s_ack_i = 1'b1;
        smp;
        if (grant_o !== 3'b001) $display("FAIL rmw_grant got=%b exp=001", grant_o); else n_pass++; n_total++;
        if (m_ack_o !== 3'b001) $display("FAIL rmw_read_ack got=%b exp=001", m_ack_o); else n_pass++; n_total++;
        tick;
        s_ack_i = 1'b0;
        m_stb_i[0] = 1'b0;
        smp;
        if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b0) $display("FAIL rmw_gap got=%b%b exp=10", s_cyc_o, s_stb_o); else n_pass++; n_total++;
        tick;
        drive(0, 1'b1, 1'b1, 1'b1, 32'h2000_0044, 32'h0000_0001);
        s_ack_i = 1'b1;
        smp;
        if (grant_o !== 3'b001) $display("FAIL rmw_hold got=%b exp=001", grant_o); else n_pass++; n_total++;
        if (s_dat_o !== 32'h0000_0001 || s_we_o !== 1'b1) $display("FAIL rmw_write got=%h we=%b exp=00000001 we=1", s_dat_o, s_we_o); else n_pass++; n_total++;
        if (m_ack_o !== 3'b001) $display("FAIL rmw_write_ack got=%b exp=001", m_ack_o); else n_pass++; n_total++;
        tick;
        s_ack_i = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick; smp;
        if (grant_o !== 3'b000) $display("FAIL rmw_idle got=%b exp=000", grant_o); else n_pass++; n_total++;
        tick; smp;
        if (grant_o !== 3'b100) $display("FAIL rmw_next got=%b exp=100", grant_o); else n_pass++; n_total++;
        if (s_adr_o !== 32'h2000_0200) $display("FAIL rmw_next_adr got=%h exp=20000200", s_adr_o); else n_pass++; n_total++;
        m_cyc_i = '0; m_stb_i = '0;
    endtask

    task automatic test_simultaneous;
        do_reset;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h2000_0300, 32'h0);
        tick; smp;
        if (grant_o !== 3'b010) $display("FAIL sim_own1 got=%b exp=010", grant_o); else n_pass++; n_total++;
        tick;
        m_cyc_i[1] = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
        s_ack_i = 1'b1;
        smp;
        if (m_ack_o !== 3'b010) $display("FAIL sim_nonowner_ack got=%b exp=010", m_ack_o); else n_pass++; n_total++;
        tick;
        s_ack_i = 1'b0;
        m_cyc_i[1] = 1'b1;
        tick; smp;
        if (grant_o !== 3'b001) $display("FAIL sim_next got=%b exp=001", grant_o); else n_pass++; n_total++;
        m_cyc_i = '0; m_stb_i = '0;
    endtask

    task automatic test_reset_mid;
        do_reset;
        drive(2, 1'b1, 1'b1, 1'b1, 32'h2000_0400, 32'h1111_2222);
        tick; smp;
        if (grant_o !== 3'b100) $display("FAIL mid_own2 got=%b exp=100", grant_o); else n_pass++; n_total++;
        tick;
        rst = 1'b1;
        tick; smp;
        if (s_cyc_o !== 1'b0) $display("FAIL mid_s_cyc got=%b exp=0", s_cyc_o); else n_pass++; n_total++;
        if (grant_o !== 3'b000) $display("FAIL mid_grant got=%b exp=000", grant_o); else n_pass++; n_total++;
        rst = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h2000_0008, 32'h0);
        tick; smp;
        if (grant_o !== 3'b001) $display("FAIL mid_first got=%b exp=001", grant_o); else n_pass++; n_total++;
        m_cyc_i = '0; m_stb_i = '0;
    endtask

    task automatic test_watchdog;
        do_reset;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h2000_0500, 32'h0);
        tick;
`ifdef GPU_FB_ARB_TIMEOUT_EN
        for (int n = 1; n <= 7; n++) begin
            smp;
            if (timeout_o !== 1'b0 || m_ack_o !== 3'b000) $display("FAIL wd_stall%0d timeout=%b ack=%b exp 0/000", n, timeout_o, m_ack_o); else n_pass++; n_total++;
            tick;
        end
        smp;
        if (timeout_o !== 1'b1) $display("FAIL wd_fire got=%b exp=1", timeout_o); else n_pass++; n_total++;
        if (m_ack_o !== 3'b010) $display("FAIL wd_ack got=%b exp=010", m_ack_o); else n_pass++; n_total++;
        if (m_dat_o !== 32'hDEAD_BEEF) $display("FAIL wd_data got=%h exp=deadbeef", m_dat_o); else n_pass++; n_total++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) $display("FAIL wd_kill got=%b%b exp=00", s_cyc_o, s_stb_o); else n_pass++; n_total++;
        tick; smp;
        if (timeout_o !== 1'b0 || grant_o !== 3'b010) $display("FAIL wd_after timeout=%b grant=%b exp 0/010", timeout_o, grant_o); else n_pass++; n_total++;
`else
        for (int n = 0; n < 100; n++) begin
            smp;
            if (timeout_o !== 1'b0 || m_ack_o !== 3'b000) $display("FAIL wd_off%0d timeout=%b ack=%b exp 0/000", n, timeout_o, m_ack_o); else n_pass++; n_total++;
            tick;
        end
        smp;
        if (grant_o !== 3'b010 || s_stb_o !== 1'b1) $display("FAIL wd_off_hang grant=%b stb=%b exp 010/1", grant_o, s_stb_o); else n_pass++; n_total++;
`endif
        m_cyc_i = '0; m_stb_i = '0;
    endtask

    initial begin
        test_reset;
        test_first_owner;
        test_round_robin;
        test_rmw;
        test_simultaneous;
        test_reset_mid;
        test_watchdog;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/gpu_fb_arbiter.md
# gpu_fb_arbiter

Round-robin Wishbone arbiter that shares the single framebuffer memory port between several GPU-side bus masters: line rasterizer, CPU direct framebuffer path and fill/blit engine. Sits between those masters and the framebuffer slave. Holds a grant for the whole `cyc` tenure so read-modify-write pixel sequences stay atomic. Optionally includes a watchdog that breaks stalled transfers.

## Interface

Parameters:
- `NUM_M`, default 3: number of masters; index 0 = raster, 1 = CPU, 2 = blit.
- `TIMEOUT_CYCLES`, default 1024: stall limit, counted from `s_stb_o` high with no `s_ack_i`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `m_cyc_i`  in  NUM_M  per-master cycle.
- `m_stb_i`  in  NUM_M  per-master strobe.
- `m_we_i`  in  NUM_M  per-master write enable.
- `m_sel_i`  in  4*NUM_M  byte selects; master k at [4k+3:4k].
- `m_adr_i`  in  32*NUM_M  addresses; master k at [32k+31:32k].
- `m_dat_i`  in  32*NUM_M  write data; master k at [32k+31:32k].
- `m_ack_o`  out  NUM_M  per-master ack.
- `m_dat_o`  out  32  read data, shared by all masters.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  framebuffer bus control.
- `s_sel_o`  out  4  framebuffer byte selects.
- `s_adr_o`  out  32  framebuffer address.
- `s_dat_o`  out  32  framebuffer write data.
- `s_dat_i`  in  32  framebuffer read data.
- `s_ack_i`  in  1  framebuffer ack.
- `grant_o`  out  NUM_M  one-hot current owner; all zero when idle.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation

- **FSM states.** IDLE and OWN.
- **IDLE.**
  - If any `m_cyc_i` bit is set, pick the first requester after `last` in circular order, then go to OWN with `gnt` registered.
  - `last` resets to NUM_M-1, so master 0 wins first.
- **OWN.** Slave outputs are a combinational mux of master `gnt`:
  - `s_cyc_o = m_cyc_i[gnt]`, `s_stb_o = m_stb_i[gnt]`.
  - `we`, `sel`, `adr` and `dat` pass through from master `gnt`.
- **Response routing.**
  - `m_ack_o[gnt] = s_ack_i`; all other ack bits are 0.
  - `m_dat_o = s_dat_i` at all times.
- **Release.**
  - When `m_cyc_i[gnt]` is low in OWN, set `last <= gnt` and go to IDLE.
  - Slave outputs drop the same cycle, since they are combinational.
- **Hold.** Dropping `stb` while `cyc` stays high keeps the grant (RMW atomicity).
- **Non-owners.** Requests from non-owners are ignored until release and never see an ack.
- **Simultaneous release and request.** The released master has the lowest priority in the next IDLE.
- **Reset mid-transfer.** Forces IDLE, clears `gnt` and zeroes all slave control outputs at the next edge. The slave must tolerate `cyc` dropping without an ack.
- **Width rule.** `gnt` is clog2(NUM_M) bits. The circular search index wraps modulo NUM_M, not modulo a power of two.

## Timing

- **Reset values.** All outputs are 0: `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_sel_o`, `s_adr_o`, `s_dat_o`, `m_ack_o`, `grant_o`, `timeout_o`. `m_dat_o` follows `s_dat_i`.
- **Arbitration latency.**
  - Request seen in IDLE at edge t.
  - `grant_o` and slave outputs are valid after edge t+1.
  - So there is one idle cycle between back-to-back owners.
- **Data path.** Zero added latency through the slave request path and through `ack`/`dat` back to the owner.
- **Fairness.** Worst-case wait is (NUM_M-1) full tenures plus NUM_M arbitration cycles.

## Configuration

`GPU_FB_ARB_TIMEOUT_EN`

**Defined:**
- A counter increments each cycle in OWN with `s_stb_o` high and `s_ack_i` low, and clears on ack or in IDLE.
- At TIMEOUT_CYCLES, for one cycle:
  - the counter clears;
  - `m_ack_o[gnt]` is forced high with `m_dat_o = 32'hDEADBEEF`;
  - `timeout_o` is pulsed;
  - `s_cyc_o` and `s_stb_o` are forced low.
- The FSM stays in OWN; the master decides whether to retry.

**Undefined:**
- No counter exists and `timeout_o` is tied 0.
- A stalled slave hangs its owner indefinitely.

## Structure

- **Package `gpu_pkg`:**
  - master index constants `GPU_M_RASTER=0`, `GPU_M_CPU=1`, `GPU_M_BLIT=2`;
  - `GPU_FB_BASE=32'h20000000`;
  - `GPU_BUS_ERR_DATA=32'hDEADBEEF`;
  - arbiter state enum.
- **Sub-module `gpu_rr_pick`:** combinational round-robin picker. Inputs are the request vector and `last`; outputs are `found` and `idx`.
- **Top level:** the FSM, registers, muxing and watchdog.

## Test plan

- **Reset, then first owner.** Assert `m_cyc_i=3'b001` with a read at 0x20000040; slave acks after 2 cycles with 0x00000080 → `grant_o=001` after one cycle, `s_adr_o=0x20000040`, `m_ack_o=001` and `m_dat_o=0x00000080` on the slave-ack cycle.
- **Round-robin rotation.** Hold all three `cyc` high, each releasing after one ack → grant sequence 0,1,2,0, with one idle cycle between each.
- **RMW atomicity.** Master 0 reads, drops `stb` for 1 cycle, then writes 0x00000001 with `cyc` held high, while master 2 requests → master 2 is not granted until master 0's `cyc` falls, and `s_dat_o=0x00000001` during the write.
- **Simultaneous release and request.** Master 1 releases while master 1 and master 0 both request → master 0 is granted next.
- **Reset mid-transfer.** Assert `rst` during OWN for master 2 → the next cycle has `s_cyc_o=0`, `grant_o=000`, and master 0 is granted first afterwards.
- **Watchdog (with `GPU_FB_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8).** Slave never acks → on the 8th stalled cycle `timeout_o=1`, `m_ack_o[gnt]=1` and `m_dat_o=0xDEADBEEF`. Without the macro → no ack and `timeout_o` stays 0 for 100 cycles.
